zone_water_scheduler: RTL and testbench

//  Shares one pump among NZONES irrigation zones. Each zone's moisture FSM raises a level

---
 rtl/zone_water_scheduler.sv | 122 ++++++++++++
 tb/tb_zone_water_scheduler.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/zone_water_scheduler.sv
// Round-robin pump scheduler: grants one irrigation zone at a time, runs the pump
// for that zone's latched duration, then enforces an all-off settling gap.
module zone_water_scheduler #(
    parameter int unsigned NZONES = 4,
    parameter int unsigned TW     = 7,
    parameter int unsigned GAP    = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NZONES-1:0]           req,
    input  logic [NZONES*TW-1:0]        dur,
    output logic                        pump_on,
    output logic [NZONES-1:0]           valve,
    output logic [$clog2(NZONES)-1:0]   grant_id,
    output logic [NZONES-1:0]           done,
    output logic [1:0]                  state
);

    localparam int unsigned IDW = $clog2(NZONES);
    localparam int unsigned GW  = $clog2(GAP + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        WATER  = 2'b10,
        SETTLE = 2'b01
    } state_t;

    state_t          st;
    logic [TW-1:0]   cnt;
    logic [GW-1:0]   gcnt;
    logic [IDW-1:0]  last;

    logic [TW-1:0]   dur_a [NZONES];
    logic [NZONES-1:0] elig;
    logic            found;
    logic [IDW-1:0]  pick;
    logic [TW-1:0]   pick_dur;
    int unsigned     j;

    // Unpack duration fields; zero-duration requests are never eligible.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NZONES; i++) begin
            dur_a[i] = dur[i*TW +: TW];
            elig[i]  = req[i] && (dur[i*TW +: TW] != '0);
        end
    end

    // First eligible zone scanning last+1, last+2, ... with wrap.
    always_comb begin
        found    = 1'b0;
        pick     = '0;
        pick_dur = '0;
        j        = 0;
        for (int unsigned k = 1; k <= NZONES; k++) begin
            j = (32'(last) + k) % NZONES;
            if (!found && elig[IDW'(j)]) begin
                found    = 1'b1;
                pick     = IDW'(j);
                pick_dur = dur_a[IDW'(j)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st       <= IDLE;
            pump_on  <= 1'b0;
            valve    <= '0;
            done     <= '0;
            grant_id <= '0;
            cnt      <= '0;
            gcnt     <= '0;
            last     <= IDW'(NZONES - 1);
        end else begin
            done <= '0;
            case (st)
                IDLE: begin
                    if (found) begin
                        grant_id <= pick;
                        last     <= pick;
                        cnt      <= pick_dur;
                        valve    <= NZONES'(1) << pick;
                        pump_on  <= 1'b1;
                        st       <= WATER;
                    end
                end
                WATER: begin
                    // Completion takes priority over a request dropping on the same edge.
                    if (cnt == TW'(1)) begin
                        done[grant_id] <= 1'b1;
                        pump_on        <= 1'b0;
                        valve          <= '0;
                        cnt            <= '0;
                        gcnt           <= GW'(GAP);
                        st             <= SETTLE;
                    end else if (!req[grant_id]) begin
                        pump_on <= 1'b0;
                        valve   <= '0;
                        cnt     <= '0;
                        gcnt    <= GW'(GAP);
                        st      <= SETTLE;
                    end else if (cnt != '0) begin
                        cnt <= cnt - TW'(1);
                    end
                end
                SETTLE: begin
                    if (gcnt <= GW'(1)) begin
                        gcnt <= '0;
                        st   <= IDLE;
                    end else begin
                        gcnt <= gcnt - GW'(1);
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

    assign state = st;

endmodule

// File: tb/tb_zone_water_scheduler.sv
// Bench for zone_water_scheduler: directed scenarios plus random traffic against
// a per-edge behavioural model of the watering rules.
module tb_zone_water_scheduler;

    localparam int NZ  = 4;
    localparam int TW  = 7;
    localparam int GAP = 2;
    localparam int IDW = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NZ-1:0]     req = '0;
    logic [NZ*TW-1:0]  dur = '0;
    logic              pump_on;
    logic [NZ-1:0]     valve;
    logic [IDW-1:0]    grant_id;
    logic [NZ-1:0]     done;
    logic [1:0]        state;

    zone_water_scheduler #(.NZONES(NZ), .TW(TW), .GAP(GAP)) dut (
        .clk(clk), .reset(reset), .req(req), .dur(dur),
        .pump_on(pump_on), .valve(valve), .grant_id(grant_id),
        .done(done), .state(state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: an active watering window, or a settling countdown, or idle.
    int          m_active = 0;
    int          m_zone = 0;
    int          m_len = 0;
    int          m_elapsed = 0;
    int          m_gap = 0;
    int          m_last = NZ - 1;
    int          m_gid = 0;
    logic [NZ-1:0] m_done = '0;

    int   obs_grants[$];
    logic prev_pump = 1'b0;
    int   pump_cnt = 0;
    int   done_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int field(input int z);
        return int'(TW'(dur >> (z * TW)));
    endfunction

    task automatic set_dur(input int z, input int v);
        dur[z*TW +: TW] = TW'(v);
    endtask

    task automatic all_dur(input int v);
        for (int z = 0; z < NZ; z++) set_dur(z, v);
    endtask

    task automatic model_edge();
        if (reset) begin
            m_active = 0; m_zone = 0; m_len = 0; m_elapsed = 0;
            m_gap = 0; m_last = NZ - 1; m_gid = 0; m_done = '0;
        end else begin
            m_done = '0;
            if (m_active != 0) begin
                m_elapsed++;
                if (m_elapsed == m_len) begin
                    m_done[m_zone] = 1'b1;
                    m_active = 0;
                    m_gap = GAP;
                end else if (!req[m_zone]) begin
                    m_active = 0;
                    m_gap = GAP;
                end
            end else if (m_gap > 0) begin
                m_gap--;
            end else begin
                for (int k = 1; k <= NZ; k++) begin
                    int z;
                    z = (m_last + k) % NZ;
                    if (req[z] && field(z) != 0) begin
                        m_active = 1; m_zone = z; m_gid = z; m_last = z;
                        m_len = field(z); m_elapsed = 0;
                        break;
                    end
                end
            end
        end
    endtask

    task automatic step();
        logic [NZ-1:0] ev;
        logic [1:0]    es;
        @(posedge clk);
        model_edge();
        #1;
        ev = (m_active != 0) ? NZ'(1) << m_zone : '0;
        es = (m_active != 0) ? 2'b10 : ((m_gap > 0) ? 2'b01 : 2'b00);
        check_eq("pump_on", pump_on, m_active);
        check_eq("valve", valve, ev);
        check_eq("grant_id", grant_id, m_gid);
        check_eq("done", done, m_done);
        check_eq("state", state, es);
        if (pump_on && !prev_pump) obs_grants.push_back(int'(grant_id));
        prev_pump = pump_on;
        if (pump_on) pump_cnt++;
        if (done != '0) done_cnt++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic run_until_done(input int budget);
        int b = 0;
        while (done_cnt == 0 && b < budget) begin
            step();
            b++;
        end
    endtask

    function automatic int grant_at(input int i);
        return (obs_grants.size() > i) ? obs_grants[i] : 99;
    endfunction

    initial begin
        // 1: reset held with all zones requesting
        req = 4'b1111;
        all_dur(3);
        repeat (3) begin
            step();
            check_eq("s1_rst_pump", pump_on, 0);
            check_eq("s1_rst_state", state, 0);
        end
        reset = 1'b0;
        obs_grants.delete();
        repeat (2) step();
        check_eq("s1_first_grant", grant_at(0), 0);
        req = '0;
        repeat (8) step();

        // 2: single zone, full completion
        do_reset();
        dur = '0;
        set_dur(1, 3);
        req = 4'b0010;
        pump_cnt = 0; done_cnt = 0; obs_grants.delete();
        run_until_done(20);
        req = '0;
        repeat (5) step();
        check_eq("s2_pump_cycles", pump_cnt, 3);
        check_eq("s2_done_pulses", done_cnt, 1);
        check_eq("s2_grant", grant_at(0), 1);

        // 3: all zones, round-robin order
        do_reset();
        req = 4'b1111;
        all_dur(2);
        obs_grants.delete();
        repeat (24) step();
        for (int i = 0; i < 5; i++)
            check_eq($sformatf("s3_grant%0d", i), grant_at(i), i % NZ);
        req = '0;
        repeat (6) step();

        // 4: abort of zone 2, then zone 3 served
        do_reset();
        dur = '0;
        set_dur(2, 10);
        set_dur(3, 3);
        req = 4'b1100;
        obs_grants.delete();
        repeat (4) step();
        req = 4'b1000;
        done_cnt = 0;
        repeat (3) step();
        check_eq("s4_no_done", done_cnt, 0);
        check_eq("s4_off_after_abort", pump_on, 0);
        repeat (2) step();
        check_eq("s4_first", grant_at(0), 2);
        check_eq("s4_next", grant_at(1), 3);
        req = '0;
        repeat (8) step();

        // 5: zero-duration request ignored, duration latched at grant
        do_reset();
        dur = '0;
        set_dur(2, 5);
        req = 4'b0101;
        pump_cnt = 0; done_cnt = 0; obs_grants.delete();
        step();
        set_dur(2, 1);
        run_until_done(20);
        req = '0;
        repeat (5) step();
        check_eq("s5_pump_cycles", pump_cnt, 5);
        check_eq("s5_grant", grant_at(0), 2);
        check_eq("s5_grants", obs_grants.size(), 1);

        // 6: reset during a watering window
        do_reset();
        dur = '0;
        set_dur(1, 8);
        req = 4'b0010;
        repeat (5) step();
        reset = 1'b1;
        done_cnt = 0;
        step();
        check_eq("s6_pump", pump_on, 0);
        check_eq("s6_valve", valve, 0);
        check_eq("s6_state", state, 0);
        check_eq("s6_no_done", done_cnt, 0);
        reset = 1'b0;
        req = 4'b1111;
        all_dur(2);
        obs_grants.delete();
        step();
        check_eq("s6_rr_restart", grant_at(0), 0);

        // random traffic
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            for (int z = 0; z < NZ; z++) begin
                if ($urandom_range(7) == 0) req[z] = ~req[z];
                if ($urandom_range(15) == 0) set_dur(z, int'($urandom_range(9)));
            end
            reset = ($urandom_range(199) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end

endmodule
